// File: rtl/xdisp2hex_capture.sv
// xdisp2hex_capture: readback decoder for a multiplexed, active-low 7-segment bus.
// Each stable segment pattern is turned back into its hex nibble, and the
// nibbles are assembled into one N_DIGITS-nibble word handed out with valid/ready.
//
// Optional feature: define XDISP_ERRCNT_EN to enable an 8-bit saturating count of
// err pulses. When it is left undefined, err_count reads 0 and the counter is absent.
//
// State table (FSM):
//   state       | meaning
//   ST_COLLECT  | stable digits are committed into out_data/digit_ok
//   ST_EMIT     | word complete, out_valid=1, word frozen until out_ready
module xdisp2hex_capture #(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_DIGITS-1:0]     an,
    input  logic [6:0]              seg,
    input  logic                    out_ready,
    output logic [4*N_DIGITS-1:0]   out_data,
    output logic                    out_valid,
    output logic [N_DIGITS-1:0]     digit_ok,
    output logic                    err,
    output logic [7:0]              err_count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } state_t;

    // True when exactly one anode line is pulled low.
    function automatic logic one_low(input logic [N_DIGITS-1:0] a);
        int n;
        n = 0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!a[i]) n++;
        end
        return (n == 1);
    endfunction

    // Segment pattern to {hit, nibble}; hit=0 for blank or unknown patterns.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'h40:   return {1'b1, 4'h0};
            7'h79:   return {1'b1, 4'h1};
            7'h24:   return {1'b1, 4'h2};
            7'h30:   return {1'b1, 4'h3};
            7'h19:   return {1'b1, 4'h4};
            7'h12:   return {1'b1, 4'h5};
            7'h02:   return {1'b1, 4'h6};
            7'h78:   return {1'b1, 4'h7};
            7'h00:   return {1'b1, 4'h8};
            7'h10:   return {1'b1, 4'h9};
            7'h08:   return {1'b1, 4'hA};
            7'h03:   return {1'b1, 4'hB};
            7'h46:   return {1'b1, 4'hC};
            7'h21:   return {1'b1, 4'hD};
            7'h06:   return {1'b1, 4'hE};
            7'h0E:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    // Sample stage (S) and the previous sample it is compared against.
    logic [N_DIGITS-1:0]    s_an_q, s_an_d;
    logic [6:0]             s_seg_q, s_seg_d;
    logic [N_DIGITS-1:0]    p_an_q, p_an_d;
    logic [6:0]             p_seg_q, p_seg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    state_t                 state_q, state_d;
    logic [4*N_DIGITS-1:0]  out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic [N_DIGITS-1:0]    digit_ok_q, digit_ok_d;
    logic                   err_q, err_d;

    logic                   sel_ok;
    logic                   same;
    logic                   evt;
    logic [4:0]             dec;
    logic                   blank;

    // Stability tracking: run length of identical, validly-selected samples.
    always_comb begin
        s_an_d  = an;
        s_seg_d = seg;
        p_an_d  = s_an_q;
        p_seg_d = s_seg_q;
        sel_ok  = one_low(s_an_q);
        same    = sel_ok && (s_an_q == p_an_q) && (s_seg_q == p_seg_q);
        if (!sel_ok) begin
            cnt_d = '0;
        end else if (!same) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Fires only on the step into saturation, so once per run.
        evt   = same && (cnt_q == CNT_PRE);
        dec   = seg_decode(s_seg_q);
        blank = (s_seg_q == SEG_BLANK);
    end

    // Next-state and output logic for the collect/emit controller.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        digit_ok_d  = digit_ok_q;
        err_d       = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (evt) begin
                    if (dec[4]) begin
                        // The low anode bit doubles as the one-hot digit mask.
                        for (int i = 0; i < N_DIGITS; i++) begin
                            if (!s_an_q[i]) begin
                                out_data_d[4*i +: 4] = dec[3:0];
                                digit_ok_d[i]        = 1'b1;
                            end
                        end
                    end else if (!blank) begin
                        err_d = 1'b1;
                    end
                end
                // Full word seen on the registered flags: present it next cycle.
                if (&digit_ok_q) begin
                    state_d     = ST_EMIT;
                    out_valid_d = 1'b1;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    state_d     = ST_COLLECT;
                    out_valid_d = 1'b0;
                    digit_ok_d  = '0;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // All datapath and FSM registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_an_q      <= '1;
            s_seg_q     <= SEG_BLANK;
            p_an_q      <= '1;
            p_seg_q     <= SEG_BLANK;
            cnt_q       <= '0;
            state_q     <= ST_COLLECT;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            digit_ok_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            s_an_q      <= s_an_d;
            s_seg_q     <= s_seg_d;
            p_an_q      <= p_an_d;
            p_seg_q     <= p_seg_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            digit_ok_q  <= digit_ok_d;
            err_q       <= err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign digit_ok  = digit_ok_q;
    assign err       = err_q;

`ifdef XDISP_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Saturating count, stepped together with the err pulse it counts.
    always_comb begin
        err_count_d = err_count_q;
        if (err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Error counter register; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= 8'h00;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'h00;
`endif

endmodule
